// File: rtl/uart_rx_frame_fsm_pkg.sv
// Shared UART receive-side definitions.
//   - 3-bit frame state encoding (IDLE..STOP) and its enum type
//   - parity-type constants (PAR_EVEN / PAR_ODD)
//   - default data width and bit-counter width helper
package uart_rx_frame_fsm_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } rx_state_e;

    // Bit counter needs clog2(width) bits; keep at least one bit for width 1.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_par_check.sv
// Combinational parity generator.
//   i_data    : data word
//   i_par_typ : PAR_EVEN / PAR_ODD
//   o_par     : parity bit the line should carry for i_data
module uart_rx_par_check
    import uart_rx_frame_fsm_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_typ,
    output logic                  o_par
);

    assign o_par = (^i_data) ^ (i_par_typ == PAR_ODD);

endmodule

// File: rtl/uart_rx_frame_fsm.sv
// UART receive frame controller, downstream of the oversampling/majority stage.
// Detects the start edge on RX_IN, then consumes one voted bit per sample_done
// strobe: start, DATA_WIDTH data bits (LSB first), optional parity, stop.
//   CLK, RST          : clock, async active-low reset
//   RX_IN             : raw line, only looked at in IDLE for start detection
//   S_BIT/sample_done : voted bit and its one-cycle strobe
//   PAR_EN/PAR_TYP    : parity config, latched at start detection
//   SAMPLE_EN, BUSY   : high whenever a frame is in progress
//   P_DATA            : last good word; DATA_VALID pulses when it updates
//   PAR_ERR, STP_ERR  : one-cycle frame-end error pulses
module uart_rx_frame_fsm
    import uart_rx_frame_fsm_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  S_BIT,
    input  logic                  sample_done,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  SAMPLE_EN,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  BUSY
);

    localparam int              CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    rx_state_e             r_state;
    rx_state_e             w_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_err;
    logic                  w_par_exp;

    uart_rx_par_check #(.DATA_WIDTH(DATA_WIDTH)) u_par_check (
        .i_data    (r_shift),
        .i_par_typ (r_par_typ),
        .o_par     (w_par_exp)
    );

    assign BUSY      = (r_state != IDLE);
    assign SAMPLE_EN = BUSY;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (!RX_IN)      w_next = START;
            // A high start sample is a line glitch: drop back silently.
            START:  if (sample_done) w_next = S_BIT ? IDLE : DATA;
            DATA:   if (sample_done && (r_cnt == LAST_BIT))
                                     w_next = r_par_en ? PARITY : STOP;
            PARITY: if (sample_done) w_next = STOP;
            STOP:   if (sample_done) w_next = IDLE;
            default:                 w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_err  <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            case (r_state)
                IDLE: if (!RX_IN) begin
                    // Config frozen for the whole frame from here on.
                    r_par_en  <= PAR_EN;
                    r_par_typ <= PAR_TYP;
                    r_par_err <= 1'b0;
                end
                START: if (sample_done) r_cnt <= '0;
                DATA: if (sample_done) begin
                    r_shift[r_cnt] <= S_BIT;
                    if (r_cnt != LAST_BIT) r_cnt <= r_cnt + 1'b1;
                end
                PARITY: if (sample_done) r_par_err <= (S_BIT != w_par_exp);
                // r_par_err only ever sets in PARITY, so it stays 0 without parity.
                STOP: if (sample_done) begin
                    if (!r_par_err && S_BIT) begin
                        DATA_VALID <= 1'b1;
                        P_DATA     <= r_shift;
                    end else begin
                        PAR_ERR <= r_par_err;
                        STP_ERR <= ~S_BIT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
